// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC sequencer. Issues word-index fetch addresses to a
// 1-cycle-latency instruction memory, pairs each returned word with its PC,
// holds the presented word across decode stalls and handles redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic        if_valid_o,
    output logic        align_err_o,
    output logic        range_err_o
);

    localparam logic [31:0] IMEM_WORDS_C = 32'(IMEM_WORDS);

    logic [31:0] pc_r, pc_n_s;
    logic [31:0] req_pc_r, req_pc_n_s;
    logic        req_vld_r, req_vld_n_s;
    logic [31:0] hold_inst_r, hold_inst_n_s;
    logic        hold_vld_r, hold_vld_n_s;
    logic        align_err_r, align_err_n_s;
    logic        range_err_r, range_err_n_s;
    logic [31:0] fpc_s;
    logic        range_hit_s;
    logic        align_hit_s;

    // Fetch address: a redirect target (forced word-aligned) overrides the sequential PC.
    always_comb begin
        if (redirect_i) begin
            fpc_s = {redirect_pc_i[31:2], 2'b00};
        end else begin
            fpc_s = pc_r;
        end
        imem_addr_o = {2'b00, fpc_s[31:2]};
        range_hit_s = ({2'b00, fpc_s[31:2]} >= IMEM_WORDS_C);
        align_hit_s = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    end

    // Next-state: redirect beats stall beats sequential advance; error flags are sticky.
    always_comb begin
        pc_n_s        = pc_r;
        req_pc_n_s    = req_pc_r;
        req_vld_n_s   = req_vld_r;
        hold_inst_n_s = hold_inst_r;
        hold_vld_n_s  = hold_vld_r;
        align_err_n_s = align_err_r | align_hit_s;
        range_err_n_s = range_err_r | range_hit_s;
        if (redirect_i) begin
            pc_n_s       = fpc_s + 32'd4;
            req_pc_n_s   = fpc_s;
            req_vld_n_s  = 1'b1;
            hold_vld_n_s = 1'b0;
        end else if (stall_i) begin
            // Memory keeps re-reading pc_r during a stall, so the word on
            // imem_inst_i must be captured on the first stalled edge only.
            if (!hold_vld_r) begin
                hold_inst_n_s = imem_inst_i;
                hold_vld_n_s  = 1'b1;
            end else begin
                hold_inst_n_s = hold_inst_r;
                hold_vld_n_s  = 1'b1;
            end
        end else begin
            pc_n_s       = pc_r + 32'd4;
            req_pc_n_s   = pc_r;
            req_vld_n_s  = 1'b1;
            hold_vld_n_s = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            req_pc_r    <= 32'h0000_0000;
            req_vld_r   <= 1'b0;
            hold_inst_r <= 32'h0000_0000;
            hold_vld_r  <= 1'b0;
            align_err_r <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            pc_r        <= pc_n_s;
            req_pc_r    <= req_pc_n_s;
            req_vld_r   <= req_vld_n_s;
            hold_inst_r <= hold_inst_n_s;
            hold_vld_r  <= hold_vld_n_s;
            align_err_r <= align_err_n_s;
            range_err_r <= range_err_n_s;
        end
    end

    // Presented instruction: held word during a stall, else the live memory word; zeroed in reset.
    always_comb begin
        if (rst) begin
            if_inst_o  = 32'h0000_0000;
            if_pc_o    = 32'h0000_0000;
            if_valid_o = 1'b0;
        end else begin
            if_inst_o  = hold_vld_r ? hold_inst_r : imem_inst_i;
            if_pc_o    = req_pc_r;
            if_valid_o = req_vld_r & ~redirect_i;
        end
        if_pc4_o    = if_pc_o + 32'd4;
        align_err_o = align_err_r;
        range_err_o = range_err_r;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit. A stream-level model predicts
// which PC decode should see each cycle; memory word at index a holds
// 32'h1000_0000 + a. A second instance checks the wrapping reset vector.
module tb_fetch_unit;

    localparam logic [31:0] RESET_A = 32'h0000_0000;
    localparam logic [31:0] RESET_B = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;

    logic [31:0] addr_a, inst_a, mem_a, pc_a, pc4_a;
    logic        valid_a, align_a, range_a;

    logic        stall_b, redirect_b;
    logic [31:0] target_b;
    logic [31:0] addr_b, inst_b, mem_b, pc_b, pc4_b;
    logic        valid_b, align_b, range_b;

    int checks;
    int errors;

    fetch_unit #(.RESET_PC(RESET_A), .IMEM_WORDS(64)) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(target), .imem_addr_o(addr_a), .imem_inst_i(mem_a),
        .if_inst_o(inst_a), .if_pc_o(pc_a), .if_pc4_o(pc4_a),
        .if_valid_o(valid_a), .align_err_o(align_a), .range_err_o(range_a)
    );

    fetch_unit #(.RESET_PC(RESET_B), .IMEM_WORDS(64)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall_b), .redirect_i(redirect_b),
        .redirect_pc_i(target_b), .imem_addr_o(addr_b), .imem_inst_i(mem_b),
        .if_inst_o(inst_b), .if_pc_o(pc_b), .if_pc4_o(pc4_b),
        .if_valid_o(valid_b), .align_err_o(align_b), .range_err_o(range_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered instruction memories: word at index a is 32'h1000_0000 + a.
    always @(posedge clk) begin
        mem_a <= 32'h1000_0000 + addr_a;
        mem_b <= 32'h1000_0000 + addr_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream model for dut_a: m_valid/m_pc is the word decode is offered,
    // m_nxt is the PC that follows it in program order.
    logic        m_live = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_nxt;
    logic        m_align;
    logic        m_range;
    logic [31:0] m_addr;

    assign m_addr = redirect ? {2'b00, target[31:2]} : {2'b00, m_nxt[31:2]};

    // Model update at each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1'b1;
            m_valid <= 1'b0;
            m_nxt   <= RESET_A;
            m_align <= 1'b0;
            m_range <= 1'b0;
        end else if (m_live) begin
            if (m_addr >= 32'd64) m_range <= 1'b1;
            if (redirect) begin
                if (target[1:0] != 2'b00) m_align <= 1'b1;
                m_valid <= 1'b1;
                m_pc    <= {target[31:2], 2'b00};
                m_nxt   <= {target[31:2], 2'b00} + 32'd4;
            end else if (!stall) begin
                m_valid <= 1'b1;
                m_pc    <= m_nxt;
                m_nxt   <= m_nxt + 32'd4;
            end
        end
    end

    // Compare dut_a against the model mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", {31'd0, valid_a}, 32'd0);
            chk("rst_inst", inst_a, 32'd0);
            chk("rst_pc", pc_a, 32'd0);
        end else if (m_live) begin
            chk("valid", {31'd0, valid_a}, {31'd0, m_valid & ~redirect});
            chk("addr", addr_a, m_addr);
            chk("align_err", {31'd0, align_a}, {31'd0, m_align});
            chk("range_err", {31'd0, range_a}, {31'd0, m_range});
            if (m_valid && !redirect) begin
                chk("pc", pc_a, m_pc);
                chk("pc4", pc4_a, m_pc + 32'd4);
                chk("inst", inst_a, 32'h1000_0000 + {2'b00, m_pc[31:2]});
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst      = r;
        stall    = s;
        redirect = rd;
        target   = t;
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        target     = 32'd0;
        stall_b    = 1'b0;
        redirect_b = 1'b0;
        target_b   = 32'd0;

        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);

        // T1 reset release and sequential fetch; T5 wrap on dut_b
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t1_c1_valid", {31'd0, valid_a}, 32'd0);
        chk("t1_c1_addr", addr_a, 32'd0);
        chk("t5_c1_valid", {31'd0, valid_b}, 32'd0);
        chk("t5_c1_addr", addr_b, 32'h3FFF_FFFE);
        chk("t5_c1_range", {31'd0, range_b}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t1_c2_pc", pc_a, 32'd0);
        chk("t1_c2_inst", inst_a, 32'h1000_0000);
        chk("t1_c2_addr", addr_a, 32'd1);
        chk("t5_c2_pc", pc_b, 32'hFFFF_FFF8);
        chk("t5_c2_inst", inst_b, 32'h4FFF_FFFE);
        chk("t5_c2_range", {31'd0, range_b}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t1_c3_pc", pc_a, 32'd4);
        chk("t5_c3_pc", pc_b, 32'hFFFF_FFFC);
        chk("t5_c3_pc4", pc4_b, 32'd0);
        chk("t5_c3_inst", inst_b, 32'h4FFF_FFFF);

        // T2 three-cycle stall with pc 8 presented
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t2_s1_pc", pc_a, 32'd8);
        chk("t2_s1_inst", inst_a, 32'h1000_0002);
        chk("t5_c4_pc", pc_b, 32'd0);
        chk("t5_c4_inst", inst_b, 32'h1000_0000);
        chk("t5_c4_valid", {31'd0, valid_b}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t2_s2_inst", inst_a, 32'h1000_0002);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t2_s3_pc", pc_a, 32'd8);
        chk("t2_s3_inst", inst_a, 32'h1000_0002);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t2_rel_pc", pc_a, 32'd8);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t2_next_pc", pc_a, 32'd12);
        chk("t2_next_inst", inst_a, 32'h1000_0003);
        drive(1'b0, 1'b0, 1'b0, 32'd0);

        // T3 redirect to 0x20 while pc 4 presented
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        chk("t3_redir_valid", {31'd0, valid_a}, 32'd0);
        chk("t3_redir_addr", addr_a, 32'd8);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t3_tgt_pc", pc_a, 32'h0000_0020);
        chk("t3_tgt_inst", inst_a, 32'h1000_0008);

        // T4 redirect together with stall (hold already full), then misaligned target
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t4_pre_pc", pc_a, 32'h0000_0024);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0010);
        chk("t4_rs_valid", {31'd0, valid_a}, 32'd0);
        chk("t4_rs_addr", addr_a, 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t4_rs_pc", pc_a, 32'h0000_0010);
        chk("t4_rs_inst", inst_a, 32'h1000_0004);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0013);
        chk("t4_mis_addr", addr_a, 32'd4);
        chk("t4_mis_align_pre", {31'd0, align_a}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t4_mis_pc", pc_a, 32'h0000_0010);
        chk("t4_mis_align", {31'd0, align_a}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t4_align_sticky", {31'd0, align_a}, 32'd1);

        // Range boundary: index 63 is legal, 64 is not
        drive(1'b0, 1'b0, 1'b1, 32'h0000_00FC);
        chk("rng_addr63", addr_a, 32'd63);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("rng_pc_fc", pc_a, 32'h0000_00FC);
        chk("rng_63_ok", {31'd0, range_a}, 32'd0);
        chk("rng_addr64", addr_a, 32'd64);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("rng_64_err", {31'd0, range_a}, 32'd1);
        chk("rng_inst64", inst_a, 32'h1000_0040);

        // T6 reset during a two-cycle stall
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t6_rst_valid", {31'd0, valid_a}, 32'd0);
        chk("t6_rst_inst", inst_a, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t6_c1_valid", {31'd0, valid_a}, 32'd0);
        chk("t6_c1_addr", addr_a, 32'd0);
        chk("t6_c1_align", {31'd0, align_a}, 32'd0);
        chk("t6_c1_range", {31'd0, range_a}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t6_c2_pc", pc_a, 32'd0);
        chk("t6_c2_inst", inst_a, 32'h1000_0000);
        drive(1'b0, 1'b0, 1'b0, 32'd0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
